// File: rtl/matmul_job_scheduler.sv
// Round-robin front end that fetches A/B, runs a shared 3x3 multiplier, and writes C back.
// One job at a time. Fetch is 19 cycles. Result writes land one cycle after mm_c_valid; req stays high until done/err.
module matmul_job_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 66,
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                req,
    input  logic [2*ADDR_WIDTH-1:0]   a_base,
    input  logic [2*ADDR_WIDTH-1:0]   b_base,
    input  logic [2*ADDR_WIDTH-1:0]   c_base,
    output logic [1:0]                grant,
    output logic [1:0]                job_done,
    output logic [1:0]                job_err,
    output logic                      mem_ren,
    output logic [ADDR_WIDTH-1:0]     mem_raddr,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic                      mem_wen,
    output logic [ADDR_WIDTH-1:0]     mem_waddr,
    output logic [ACC_WIDTH-1:0]      mem_wdata,
    output logic                      mm_start,
    output logic                      mm_a_wen,
    output logic                      mm_b_wen,
    output logic [3:0]                mm_a_addr,
    output logic [3:0]                mm_b_addr,
    output logic [DATA_WIDTH-1:0]     mm_a_in,
    output logic [DATA_WIDTH-1:0]     mm_b_in,
    input  logic [ACC_WIDTH-1:0]      mm_c_out,
    input  logic                      mm_c_valid,
    input  logic [1:0]                mm_row,
    input  logic [1:0]                mm_col,
    input  logic                      mm_done
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        START   = 3'd2,
        COLLECT = 3'd3,
        RELEASE = 3'd4,
        FINISH  = 3'd5
    } state_t;

    state_t                 state_q;
    logic [4:0]             idx_q;
    logic [1:0]             grant_q;
    logic                   gsel_q;
    logic                   last_q;
    logic [ADDR_WIDTH-1:0]  a_q, b_q, c_q;
    logic [WD_W-1:0]        wd_q;
    logic [3:0]             wr_cnt_q;
    logic [1:0]             job_done_q, job_err_q;
    logic                   mem_ren_q, mem_wen_q;
    logic [ADDR_WIDTH-1:0]  mem_raddr_q, mem_waddr_q;
    logic [ACC_WIDTH-1:0]   mem_wdata_q;
    logic                   mm_start_q, mm_a_wen_q, mm_b_wen_q;
    logic [3:0]             mm_a_addr_q, mm_b_addr_q;

    logic                   pick_d;
    logic [ADDR_WIDTH-1:0]  a_sel_d, b_sel_d, c_sel_d;
    logic [4:0]             nxt_idx_d;
    logic [ADDR_WIDTH-1:0]  fetch_addr_d;
    logic [3:0]             c_off_d;
    logic [ADDR_WIDTH-1:0]  waddr_d;

    // Tie goes to whoever was not served last; last_q resets to 1 so requester 0 wins first.
    always_comb begin
        pick_d = 1'b0;
        if (req == 2'b10)
            pick_d = 1'b1;
        else if (req == 2'b11)
            pick_d = ~last_q;
        a_sel_d = pick_d ? a_base[2*ADDR_WIDTH-1:ADDR_WIDTH] : a_base[ADDR_WIDTH-1:0];
        b_sel_d = pick_d ? b_base[2*ADDR_WIDTH-1:ADDR_WIDTH] : b_base[ADDR_WIDTH-1:0];
        c_sel_d = pick_d ? c_base[2*ADDR_WIDTH-1:ADDR_WIDTH] : c_base[ADDR_WIDTH-1:0];
    end

    always_comb begin
        nxt_idx_d = idx_q + 5'd1;
        if (nxt_idx_d < 5'd9)
            fetch_addr_d = a_q + ADDR_WIDTH'(nxt_idx_d);
        else
            fetch_addr_d = b_q + ADDR_WIDTH'(nxt_idx_d - 5'd9);
        c_off_d = ({2'b00, mm_row} * 4'd3) + {2'b00, mm_col};
        waddr_d = c_q + ADDR_WIDTH'(c_off_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            grant_q     <= '0;
            gsel_q      <= 1'b0;
            last_q      <= 1'b1;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            wd_q        <= '0;
            wr_cnt_q    <= '0;
            job_done_q  <= '0;
            job_err_q   <= '0;
            mem_ren_q   <= 1'b0;
            mem_raddr_q <= '0;
            mem_wen_q   <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            mm_start_q  <= 1'b0;
            mm_a_wen_q  <= 1'b0;
            mm_b_wen_q  <= 1'b0;
            mm_a_addr_q <= '0;
            mm_b_addr_q <= '0;
        end else begin
            mem_wen_q  <= 1'b0;
            mm_a_wen_q <= 1'b0;
            mm_b_wen_q <= 1'b0;
            job_done_q <= '0;
            job_err_q  <= '0;

            case (state_q)
                IDLE: begin
                    if (|req) begin
                        gsel_q      <= pick_d;
                        grant_q     <= pick_d ? 2'b10 : 2'b01;
                        a_q         <= a_sel_d;
                        b_q         <= b_sel_d;
                        c_q         <= c_sel_d;
                        idx_q       <= '0;
                        mem_ren_q   <= 1'b1;
                        mem_raddr_q <= a_sel_d;
                        state_q     <= FETCH;
                    end
                end

                FETCH: begin
                    // The word read at idx arrives next cycle, so its load strobe is set up now.
                    if (idx_q < 5'd9) begin
                        mm_a_wen_q  <= 1'b1;
                        mm_a_addr_q <= idx_q[3:0];
                    end else if (idx_q < 5'd18) begin
                        mm_b_wen_q  <= 1'b1;
                        mm_b_addr_q <= 4'(idx_q - 5'd9);
                    end
                    if (idx_q == 5'd18) begin
                        mm_start_q <= 1'b1;
                        wd_q       <= '0;
                        wr_cnt_q   <= '0;
                        state_q    <= START;
                    end else begin
                        idx_q       <= nxt_idx_d;
                        mem_ren_q   <= (idx_q < 5'd17);
                        mem_raddr_q <= fetch_addr_d;
                    end
                end

                START, COLLECT, RELEASE: begin
                    wd_q <= wd_q + WD_W'(1);
                    if (state_q == COLLECT && mm_c_valid) begin
                        mem_wen_q   <= 1'b1;
                        mem_waddr_q <= waddr_d;
                        mem_wdata_q <= mm_c_out;
                        if (wr_cnt_q != 4'hF)
                            wr_cnt_q <= wr_cnt_q + 4'd1;
                    end
                    if (wd_q == WD_LAST) begin
                        mm_start_q <= 1'b0;
                        job_err_q  <= grant_q;
                        state_q    <= FINISH;
                    end else begin
                        case (state_q)
                            START: state_q <= COLLECT;
                            COLLECT: begin
                                if (mm_done) begin
                                    mm_start_q <= 1'b0;
                                    state_q    <= RELEASE;
                                end
                            end
                            default: begin
                                if (!mm_done) begin
                                    if (wr_cnt_q == 4'd9)
                                        job_done_q <= grant_q;
                                    else
                                        job_err_q <= grant_q;
                                    state_q <= FINISH;
                                end
                            end
                        endcase
                    end
                end

                FINISH: begin
                    grant_q <= '0;
                    last_q  <= gsel_q;
                    state_q <= IDLE;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant     = grant_q;
    assign job_done  = job_done_q;
    assign job_err   = job_err_q;
    assign mem_ren   = mem_ren_q;
    assign mem_raddr = mem_raddr_q;
    assign mem_wen   = mem_wen_q;
    assign mem_waddr = mem_waddr_q;
    assign mem_wdata = mem_wdata_q;
    assign mm_start  = mm_start_q;
    assign mm_a_wen  = mm_a_wen_q;
    assign mm_b_wen  = mm_b_wen_q;
    assign mm_a_addr = mm_a_addr_q;
    assign mm_b_addr = mm_b_addr_q;
    // Read data passes straight through to the loader; masked so idle outputs stay at zero.
    assign mm_a_in   = mm_a_wen_q ? mem_rdata : '0;
    assign mm_b_in   = mm_b_wen_q ? mem_rdata : '0;

endmodule
